// File: rtl/onetothree_demux.sv
// Registered 1-to-3 stream demultiplexer: s1:s0 steers each accepted word into
// one of three one-entry output slots; select 2'b11 is dropped, flagged and counted.
module onetothree_demux #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic             y2_valid,
    input  logic             y0_ready,
    input  logic             y1_ready,
    input  logic             y2_ready,
    output logic             err,
    output logic [7:0]       drop_cnt
);
    localparam int unsigned NCH         = 3;
    localparam logic [1:0]  SEL_ILLEGAL = 2'b11;
    localparam logic [7:0]  CNT_MAX     = 8'hFF;

    logic [1:0]       sel;
    logic [NCH-1:0]   ch_ready;
    logic [NCH-1:0]   ch_valid;
    logic [NCH-1:0]   slot_free;
    logic [WIDTH-1:0] ch_data [NCH];
    logic             xfer;
    logic             xfer_illegal;

    assign sel       = {s1, s0};
    assign ch_ready  = {y2_ready, y1_ready, y0_ready};
    assign slot_free = ~ch_valid | ch_ready;

    // Slot is free when empty or draining this cycle; illegal codes always sink.
    always_comb begin
        i_ready = 1'b0;
        if (rst_n) begin
            case (sel)
                2'd0:    i_ready = slot_free[0];
                2'd1:    i_ready = slot_free[1];
                2'd2:    i_ready = slot_free[2];
                default: i_ready = 1'b1;
            endcase
        end
    end

    assign xfer         = i_valid & i_ready;
    assign xfer_illegal = xfer & (sel == SEL_ILLEGAL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NCH; n++) begin
                ch_data[n]  <= '0;
                ch_valid[n] <= 1'b0;
            end
            err      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            // Refill takes priority over drain so a same-edge swap leaves no bubble.
            for (int n = 0; n < NCH; n++) begin
                if (xfer && (sel == 2'(n))) begin
                    ch_data[n]  <= i_data;
                    ch_valid[n] <= 1'b1;
                end else if (ch_ready[n]) begin
                    ch_valid[n] <= 1'b0;
                end
            end
            err <= xfer_illegal;
            if (xfer_illegal && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign y0       = ch_data[0];
    assign y1       = ch_data[1];
    assign y2       = ch_data[2];
    assign y0_valid = ch_valid[0];
    assign y1_valid = ch_valid[1];
    assign y2_valid = ch_valid[2];

endmodule

// File: tb/tb_onetothree_demux.sv
// Bench for onetothree_demux: directed vector table, random scoreboard phase,
// then counter saturation and mid-operation reset sequences.
module tb_onetothree_demux;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NVEC  = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             i_ready;
    logic [1:0]       sel;
    logic [WIDTH-1:0] y0, y1, y2;
    logic             y0_valid, y1_valid, y2_valid;
    logic [2:0]       rdy;
    logic             err;
    logic [7:0]       drop_cnt;

    logic [2:0]       yvld;
    logic [WIDTH-1:0] yv [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign yvld  = {y2_valid, y1_valid, y0_valid};
    assign yv[0] = y0;
    assign yv[1] = y1;
    assign yv[2] = y2;

    onetothree_demux #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .s0       (sel[0]),
        .s1       (sel[1]),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y0_valid (y0_valid),
        .y1_valid (y1_valid),
        .y2_valid (y2_valid),
        .y0_ready (rdy[0]),
        .y1_ready (rdy[1]),
        .y2_ready (rdy[2]),
        .err      (err),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] s;
        logic [7:0] d;
        logic [2:0] rd;
        logic       e_irdy;
        logic [2:0] e_v;
        logic [7:0] e_y0;
        logic [7:0] e_y1;
        logic [7:0] e_y2;
        logic       e_err;
        logic [7:0] e_drop;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s,
                                input logic [7:0] d, input logic [2:0] rd,
                                input logic e_irdy, input logic [2:0] e_v,
                                input logic [7:0] e_y0, input logic [7:0] e_y1,
                                input logic [7:0] e_y2, input logic e_err,
                                input logic [7:0] e_drop);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.d = d; t.rd = rd;
        t.e_irdy = e_irdy; t.e_v = e_v;
        t.e_y0 = e_y0; t.e_y1 = e_y1; t.e_y2 = e_y2;
        t.e_err = e_err; t.e_drop = e_drop;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive a cycle's inputs on the falling edge; combinational i_ready settles after #1.
    task automatic drive(input logic r, input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic [2:0] rd);
        @(negedge clk);
        rst_n = r; i_valid = v; sel = s; i_data = d; rdy = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sbq [3][$];
    logic [7:0] e_drop;
    logic       e_err;
    logic       e_irdy;
    logic       v;
    logic [1:0] s;
    logic [7:0] d;
    logic [2:0] rd;
    int         r;

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; sel = 2'b00; i_data = '0; rdy = 3'b000;

        vecs[0]  = mk(0, 1, 0, 8'hFF, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0);
        vecs[1]  = mk(0, 1, 0, 8'hFF, 3'b111, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0);
        vecs[2]  = mk(1, 1, 0, 8'h11, 3'b111, 1, 3'b001, 8'h11, 8'h00, 8'h00, 0, 0);
        vecs[3]  = mk(1, 1, 1, 8'h22, 3'b111, 1, 3'b010, 8'h11, 8'h22, 8'h00, 0, 0);
        vecs[4]  = mk(1, 1, 2, 8'h33, 3'b111, 1, 3'b100, 8'h11, 8'h22, 8'h33, 0, 0);
        vecs[5]  = mk(1, 0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h11, 8'h22, 8'h33, 0, 0);
        vecs[6]  = mk(1, 1, 1, 8'hA0, 3'b101, 1, 3'b010, 8'h11, 8'hA0, 8'h33, 0, 0);
        vecs[7]  = mk(1, 1, 1, 8'hA1, 3'b101, 0, 3'b010, 8'h11, 8'hA0, 8'h33, 0, 0);
        vecs[8]  = mk(1, 1, 1, 8'hA1, 3'b101, 0, 3'b010, 8'h11, 8'hA0, 8'h33, 0, 0);
        vecs[9]  = mk(1, 1, 1, 8'hA1, 3'b111, 1, 3'b010, 8'h11, 8'hA1, 8'h33, 0, 0);
        vecs[10] = mk(1, 1, 0, 8'hB0, 3'b111, 1, 3'b001, 8'hB0, 8'hA1, 8'h33, 0, 0);
        vecs[11] = mk(1, 1, 2, 8'h77, 3'b111, 1, 3'b100, 8'hB0, 8'hA1, 8'h77, 0, 0);
        vecs[12] = mk(1, 1, 2, 8'h5C, 3'b111, 1, 3'b100, 8'hB0, 8'hA1, 8'h5C, 0, 0);
        vecs[13] = mk(1, 0, 0, 8'h00, 3'b111, 1, 3'b000, 8'hB0, 8'hA1, 8'h5C, 0, 0);
        vecs[14] = mk(1, 1, 3, 8'h99, 3'b111, 1, 3'b000, 8'hB0, 8'hA1, 8'h5C, 1, 1);
        vecs[15] = mk(1, 1, 3, 8'h9A, 3'b111, 1, 3'b000, 8'hB0, 8'hA1, 8'h5C, 1, 2);
        vecs[16] = mk(1, 1, 3, 8'h9B, 3'b111, 1, 3'b000, 8'hB0, 8'hA1, 8'h5C, 1, 3);
        vecs[17] = mk(1, 0, 3, 8'h00, 3'b111, 1, 3'b000, 8'hB0, 8'hA1, 8'h5C, 0, 3);
        vecs[18] = mk(1, 1, 3, 8'h9C, 3'b000, 1, 3'b000, 8'hB0, 8'hA1, 8'h5C, 1, 4);
        vecs[19] = mk(1, 0, 0, 8'h00, 3'b000, 1, 3'b000, 8'hB0, 8'hA1, 8'h5C, 0, 4);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].rd);
            chk($sformatf("vec%0d i_ready", i), 32'(i_ready), 32'(vecs[i].e_irdy));
            tick();
            chk($sformatf("vec%0d valids", i), 32'(yvld), 32'(vecs[i].e_v));
            chk($sformatf("vec%0d y0", i), 32'(y0), 32'(vecs[i].e_y0));
            chk($sformatf("vec%0d y1", i), 32'(y1), 32'(vecs[i].e_y1));
            chk($sformatf("vec%0d y2", i), 32'(y2), 32'(vecs[i].e_y2));
            chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].e_drop));
        end

        // Random traffic against per-channel scoreboard queues.
        drive(0, 0, 0, 8'h00, 3'b000);
        tick();
        e_drop = 8'd0;
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = int'($urandom_range(0, 9));
            s  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            d  = 8'($urandom);
            rd = 3'($urandom);
            drive(1, v, s, d, rd);
            if (s == 2'd3) e_irdy = 1'b1;
            else e_irdy = (sbq[s].size() == 0) || rd[s];
            chk($sformatf("rnd%0d i_ready", c), 32'(i_ready), 32'(e_irdy));
            for (int n = 0; n < 3; n++) begin
                chk($sformatf("rnd%0d y%0d_valid", c, n), 32'(yvld[n]), 32'(sbq[n].size() != 0));
                if (sbq[n].size() != 0) begin
                    chk($sformatf("rnd%0d y%0d data", c, n), 32'(yv[n]), 32'(sbq[n][0]));
                    if (rd[n]) void'(sbq[n].pop_front());
                end
            end
            e_err = 1'b0;
            if (v && e_irdy) begin
                if (s == 2'd3) begin
                    e_err = 1'b1;
                    if (e_drop != 8'hFF) e_drop = e_drop + 8'd1;
                end else begin
                    sbq[s].push_back(d);
                end
            end
            tick();
            chk($sformatf("rnd%0d err", c), 32'(err), 32'(e_err));
            chk($sformatf("rnd%0d drop_cnt", c), 32'(drop_cnt), 32'(e_drop));
        end

        // Saturation: 260 back-to-back illegal transfers.
        drive(0, 0, 0, 8'h00, 3'b111);
        tick();
        for (int k = 0; k < 260; k++) begin
            drive(1, 1, 3, 8'(k), 3'b111);
            tick();
            if (k == 100) chk("sat drop_cnt mid", 32'(drop_cnt), 32'd101);
            if (k == 259) begin
                chk("sat drop_cnt", 32'(drop_cnt), 32'd255);
                chk("sat err", 32'(err), 32'd1);
                chk("sat valids", 32'(yvld), 32'd0);
            end
        end
        drive(1, 0, 0, 8'h00, 3'b111);
        tick();
        chk("sat err clears", 32'(err), 32'd0);
        chk("sat drop_cnt holds", 32'(drop_cnt), 32'd255);

        // Reset while y0 holds an undelivered word.
        drive(1, 1, 0, 8'h42, 3'b000);
        chk("mid i_ready", 32'(i_ready), 32'd1);
        tick();
        chk("mid y0_valid", 32'(y0_valid), 32'd1);
        chk("mid y0", 32'(y0), 32'h42);
        drive(1, 0, 0, 8'h00, 3'b000);
        tick();
        chk("mid y0 held", 32'(y0), 32'h42);
        drive(0, 1, 1, 8'h55, 3'b110);
        chk("mid rst i_ready", 32'(i_ready), 32'd0);
        tick();
        chk("mid rst valids", 32'(yvld), 32'd0);
        chk("mid rst y0", 32'(y0), 32'd0);
        chk("mid rst drop_cnt", 32'(drop_cnt), 32'd0);
        chk("mid rst err", 32'(err), 32'd0);
        drive(1, 1, 1, 8'h66, 3'b111);
        chk("post rst i_ready", 32'(i_ready), 32'd1);
        tick();
        chk("post rst valids", 32'(yvld), 32'b010);
        chk("post rst y1", 32'(y1), 32'h66);
        drive(1, 0, 0, 8'h00, 3'b111);
        tick();
        chk("post rst drained", 32'(yvld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d)", checks);
        $fatal(1);
    end

endmodule
